// File: rtl/sr_sched_pkg.sv
// sr_sched_pkg: shared FSM state, op and requester encodings for sr_bank_sched
package sr_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; valid/ptr/en in, one-hot gnt and next pointer out
module rr_arb2
  import sr_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);
  assign gnt[REQ_A] = en & valid[REQ_A] & (~valid[REQ_B] | ptr == REQ_A);
  assign gnt[REQ_B] = en & valid[REQ_B] & (~valid[REQ_A] | ptr == REQ_B);
  assign ptr_nxt = gnt[REQ_A] ? REQ_B : gnt[REQ_B] ? REQ_A : ptr;
endmodule

// File: rtl/sr_bank_sched.sv
// sr_bank_sched: round-robin set/clear pulse sequencer for an SR bank; ports a_*/b_* requesters, s/r pulses, busy, sticky err, q_shadow when SR_SHADOW_EN is defined
module sr_bank_sched
  import sr_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int PULSE = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic          a_op,
  input  logic [IW-1:0] a_idx,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic          b_op,
  input  logic [IW-1:0] b_idx,
  output logic          b_ready,
  output logic [N-1:0]  s,
  output logic [N-1:0]  r,
  output logic          busy,
  output logic          err
`ifdef SR_SHADOW_EN
  ,
  output logic [N-1:0]  q_shadow
`endif
);
  localparam logic [IW:0] NL = (IW+1)'(N);
  state_t state;
  logic ptr, ptr_nxt, hs, sel, sel_op, in_range, skip;
  logic [1:0] gnt;
  logic [3:0] cnt;
  logic [IW-1:0] sel_idx;
  logic [N-1:0] sel_bit;
  rr_arb2 u_arb (
    .valid   ({b_valid, a_valid}),
    .ptr     (ptr),
    .en      (state == ST_IDLE),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );
  assign a_ready = gnt[REQ_A];
  assign b_ready = gnt[REQ_B];
  assign hs = |gnt;
  assign sel = gnt[REQ_B];
  assign sel_op = sel ? b_op : a_op;
  assign sel_idx = sel ? b_idx : a_idx;
  assign sel_bit = N'(1) << sel_idx;
  assign in_range = {1'b0, sel_idx} < NL;
`ifdef SR_SHADOW_EN
  // a command that would not change the tracked bit needs no pulse
  assign skip = q_shadow[sel_idx] == sel_op;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= REQ_A;
      cnt <= '0;
      s <= '0;
      r <= '0;
      busy <= 1'b0;
      err <= 1'b0;
`ifdef SR_SHADOW_EN
      q_shadow <= '0;
`endif
    end else
      unique case (state)
        ST_IDLE:
          if (hs) begin
            ptr <= ptr_nxt;
            if (!in_range) err <= 1'b1;
            else if (!skip) begin
              state <= ST_PULSE;
              cnt <= 4'(PULSE - 1);
              s <= sel_op == OP_SET ? sel_bit : '0;
              r <= sel_op == OP_CLR ? sel_bit : '0;
              busy <= 1'b1;
            end
          end
        ST_PULSE:
          if (cnt == '0) begin
            state <= ST_GAP;
            s <= '0;
            r <= '0;
`ifdef SR_SHADOW_EN
            q_shadow <= (q_shadow | s) & ~r;
`endif
          end else cnt <= cnt - 4'd1;
        ST_GAP: begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
endmodule
